// File: rtl/key_expansion.sv
// Iterative AES-256 key schedule: loads an 8-word cipher key, then derives one
// schedule word per cycle until all 60 words (15 round keys) are available.
module key_expansion (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [255:0]           aes_key_i,
    input  logic                   aes_key_valid_i,
    output logic [14:0][127:0]     round_keys_o,
    output logic                   round_keys_valid_o
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Byte b sits at the (255-b)th byte slot from the bottom; ~b is 255-b.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [2:0] n);
        case (n)
            3'd1:    return 8'h01;
            3'd2:    return 8'h02;
            3'd3:    return 8'h04;
            3'd4:    return 8'h08;
            3'd5:    return 8'h10;
            3'd6:    return 8'h20;
            3'd7:    return 8'h40;
            default: return 8'h00;
        endcase
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_valid_q;
    logic [5:0]  r_idx;
    logic        r_rk_valid;
    logic [31:0] r_w [60];

    logic        w_accept;
    logic        w_last;
    logic [31:0] w_prev;
    logic [31:0] w_temp;
    logic [31:0] w_new;

    always_comb begin
        w_accept    = 1'b0;
        w_last      = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                w_accept = aes_key_valid_i && !r_valid_q;
                if (w_accept) w_state_nxt = BUSY;
            end
            BUSY: begin
                w_last = (r_idx == 6'd59);
                if (w_last) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_prev = r_w[r_idx - 6'd1];
        w_temp = w_prev;
        if (r_idx[2:0] == 3'd0)
            w_temp = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {rcon(r_idx[5:3]), 24'h0};
        else if (r_idx[2:0] == 3'd4)
            w_temp = sub_word(w_prev);
        w_new = r_w[r_idx - 6'd8] ^ w_temp;
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            r_state    <= IDLE;
            r_valid_q  <= 1'b0;
            r_idx      <= 6'd8;
            r_rk_valid <= 1'b0;
            for (int k = 0; k < 60; k++) r_w[k] <= 32'h0;
        end else begin
            r_state   <= w_state_nxt;
            r_valid_q <= aes_key_valid_i;
            if (w_accept) begin
                for (int k = 0; k < 8; k++) r_w[k] <= aes_key_i[255 - 32*k -: 32];
                r_idx      <= 6'd8;
                r_rk_valid <= 1'b0;
            end else if (r_state == BUSY) begin
                r_w[r_idx] <= w_new;
                r_idx      <= r_idx + 6'd1;
                if (w_last) r_rk_valid <= 1'b1;
            end
        end
    end

    always_comb begin
        for (int r = 0; r < 15; r++)
            round_keys_o[r] = {r_w[4*r], r_w[4*r+1], r_w[4*r+2], r_w[4*r+3]};
    end

    assign round_keys_valid_o = r_rk_valid;

endmodule

// File: tb/tb_key_expansion.sv
// Bench for key_expansion: FIPS-197 vectors plus random keys, checked against a
// reference schedule built from a GF(2^8)-derived S-box.
module tb_key_expansion;

    logic               clk;
    logic               resetn;
    logic [255:0]       aes_key_i;
    logic               aes_key_valid_i;
    logic [14:0][127:0] round_keys_o;
    logic               round_keys_valid_o;

    int n_cmp = 0;
    int n_err = 0;

    key_expansion dut (
        .clk                (clk),
        .resetn             (resetn),
        .aes_key_i          (aes_key_i),
        .aes_key_valid_i    (aes_key_valid_i),
        .round_keys_o       (round_keys_o),
        .round_keys_valid_o (round_keys_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] ref_sbox(input logic [7:0] a);
        logic [7:0] inv = 8'h00;
        logic [7:0] s;
        if (a != 8'h00)
            for (int y = 1; y < 256; y++)
                if (gmul(a, 8'(y)) == 8'h01) inv = 8'(y);
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        return s;
    endfunction

    logic [7:0] sb_tab [256];

    function automatic logic [14:0][127:0] ref_schedule(input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [14:0][127:0] rk;
        for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb_tab[t[31:24]], sb_tab[t[23:16]], sb_tab[t[15:8]], sb_tab[t[7:0]]};
                t ^= {8'(1 << (i/8 - 1)), 24'h0};
            end else if (i % 8 == 4) begin
                t = {sb_tab[t[31:24]], sb_tab[t[23:16]], sb_tab[t[15:8]], sb_tab[t[7:0]]};
            end
            w[i] = w[i-8] ^ t;
        end
        for (int r = 0; r < 15; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return rk;
    endfunction

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_sched(input string tag, input logic [255:0] key);
        logic [14:0][127:0] exp = ref_schedule(key);
        for (int r = 0; r < 15; r++)
            chk($sformatf("%s rk%0d", tag, r), round_keys_o[r], exp[r]);
    endtask

    // Caller guarantees IDLE and that valid was low on the last sampled edge
    // (or reset was just released). mode 1 pokes a new key mid-expansion.
    task automatic expand(input string tag, input logic [255:0] key, input int mode);
        int cyc = 0;
        aes_key_i       = key;
        aes_key_valid_i = 1'b1;
        step();
        chk({tag, " valid at accept"}, 128'(round_keys_valid_o), 128'h0);
        aes_key_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        while (cyc < 100) begin
            if (mode == 1 && cyc == 10) aes_key_valid_i = 1'b0;
            if (mode == 1 && cyc == 11) aes_key_valid_i = 1'b1;
            step();
            cyc++;
            if (round_keys_valid_o) break;
        end
        chk({tag, " latency"}, 128'(cyc), 128'd52);
        check_sched(tag, key);
    endtask

    logic [255:0] k1, k2;

    initial begin
        for (int b = 0; b < 256; b++) sb_tab[b] = ref_sbox(8'(b));
        resetn          = 1'b1;
        aes_key_valid_i = 1'b0;
        aes_key_i       = '0;

        // Reset held with valid toggling: nothing may happen.
        for (int c = 0; c < 10; c++) begin
            aes_key_valid_i = c[0];
            aes_key_i       = {8{$urandom}};
            step();
            chk("reset valid", 128'(round_keys_valid_o), 128'h0);
            chk("reset keys", 128'(|round_keys_o), 128'h0);
        end
        aes_key_valid_i = 1'b0;
        step();
        resetn = 1'b0;
        step();

        // FIPS-197 C.3 key
        k1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        expand("C3", k1, 0);
        chk("C3 spec rk0", round_keys_o[0], 128'h000102030405060708090a0b0c0d0e0f);
        chk("C3 spec rk2", round_keys_o[2], 128'ha573c29fa176c498a97fce93a572c09c);
        chk("C3 spec rk14", round_keys_o[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);
        aes_key_valid_i = 1'b0;
        step();

        // FIPS-197 A.3 key, valid then held high
        chk("A3 valid before accept", 128'(round_keys_valid_o), 128'h1);
        k1 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        expand("A3", k1, 0);
        chk("A3 spec rk2", round_keys_o[2], 128'h9ba354118e6925afa51a8b5f2067fcde);
        chk("A3 spec rk14", round_keys_o[14], 128'hfe4890d1e6188d0b046df344706c631e);
        for (int c = 0; c < 60; c++) begin
            step();
            if (c % 10 == 9) chk("A3 held valid", 128'(round_keys_valid_o), 128'h1);
        end
        chk("A3 held rk14", round_keys_o[14], 128'hfe4890d1e6188d0b046df344706c631e);
        aes_key_valid_i = 1'b0;
        step();

        // Mid-expansion valid pulse with a different key must be ignored
        k1 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        expand("busy-ignore", k1, 1);
        aes_key_valid_i = 1'b0;
        step();

        // Reset mid-expansion; valid stays high across reset release
        k1 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        k2 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        aes_key_i       = k1;
        aes_key_valid_i = 1'b1;
        step();
        for (int c = 0; c < 20; c++) step();
        resetn = 1'b1;
        step();
        chk("midreset valid", 128'(round_keys_valid_o), 128'h0);
        chk("midreset keys", 128'(|round_keys_o), 128'h0);
        resetn = 1'b0;
        expand("after-reset", k2, 0);
        aes_key_valid_i = 1'b0;
        step();

        // Back-to-back random keys
        for (int n = 0; n < 4; n++) begin
            chk($sformatf("b2b%0d valid before", n), 128'(round_keys_valid_o), 128'h1);
            k1 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            expand($sformatf("b2b%0d", n), k1, 0);
            aes_key_valid_i = 1'b0;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
